riscv_mem_arbiter: RTL and testbench

- Shares one single-port SRAM (SP_SRAM: active-low CSN/WEN, byte enables, registered 1-cycle read data) between the core's instruction-fetch port and data port, for a unified-memory variant of RISCV_TOP.
- Issues at most one SRAM access per cycle and arbitrates contention round-robin.
- Routes read data back to the requester that issued the read.
- Keeps saturating per-port stall counters for CPI analysis alongside NUM_INST.

---
 rtl/riscv_mem_pkg.sv | 31 +++
 rtl/mem_arb_rr2.sv | 40 ++++
 rtl/riscv_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared constants and types for the unified-memory arbiter.
package riscv_mem_pkg;

    localparam int unsigned AWIDTH_DEF  = 12;
    localparam int unsigned DWIDTH_DEF  = 32;
    localparam int unsigned MAWIDTH_DEF = 10;

    // Which requester owns the read data coming back from the SRAM next cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // Requester identity used by the round-robin pointer
    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    // Grant vector bit positions
    localparam int unsigned GNT_I = 0;
    localparam int unsigned GNT_D = 1;

    // SRAM pin values when no access is issued
    localparam logic       CSN_IDLE = 1'b1;
    localparam logic       WEN_IDLE = 1'b1;
    localparam logic [3:0] BE_IDLE  = 4'h0;
    localparam logic [3:0] BE_FULL  = 4'hF;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin arbiter: grants combinationally, remembers the last winner.
module mem_arb_rr2
    import riscv_mem_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    port_e last_gnt_q;

    // Lone requester wins outright; on a tie the port that did not win last time goes first
    always_comb begin
        gnt_o = 2'b00;
        if (!RST) begin
            if (req_i[GNT_I] && req_i[GNT_D]) begin
                if (last_gnt_q == PORT_D) begin
                    gnt_o[GNT_I] = 1'b1;
                end else begin
                    gnt_o[GNT_D] = 1'b1;
                end
            end else begin
                gnt_o = req_i;
            end
        end
    end

    // Reset to D so that I wins the first tie after reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_gnt_q <= PORT_D;
        end else if (gnt_o[GNT_I]) begin
            last_gnt_q <= PORT_I;
        end else if (gnt_o[GNT_D]) begin
            last_gnt_q <= PORT_D;
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port SRAM between the fetch and data ports of the core,
// routes read data back to its requester and counts per-port stall cycles.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned AWIDTH    = AWIDTH_DEF,
    parameter int unsigned DWIDTH    = DWIDTH_DEF,
    parameter int unsigned MAWIDTH   = MAWIDTH_DEF,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    // Instruction fetch port
    input  logic                 I_REQ,
    input  logic [AWIDTH-1:0]    I_ADDR,
    output logic                 I_GNT,
    output logic                 I_RVALID,
    output logic [DWIDTH-1:0]    I_RDATA,
    // Data port
    input  logic                 D_REQ,
    input  logic                 D_WE,
    input  logic [AWIDTH-1:0]    D_ADDR,
    input  logic [3:0]           D_BE,
    input  logic [DWIDTH-1:0]    D_WDATA,
    output logic                 D_GNT,
    output logic                 D_RVALID,
    output logic [DWIDTH-1:0]    D_RDATA,
    // SRAM side
    output logic                 MEM_CSN,
    output logic                 MEM_WEN,
    output logic [3:0]           MEM_BE,
    output logic [MAWIDTH-1:0]   MEM_ADDR,
    output logic [DWIDTH-1:0]    MEM_DOUT,
    input  logic [DWIDTH-1:0]    MEM_DI,
    // Stall statistics
    output logic [CNT_WIDTH-1:0] I_STALL_CNT,
    output logic [CNT_WIDTH-1:0] D_STALL_CNT
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [1:0]           gnt;
    owner_e               owner_d, owner_q;
    logic [CNT_WIDTH-1:0] i_stall_d, i_stall_q;
    logic [CNT_WIDTH-1:0] d_stall_d, d_stall_q;

    // Byte-offset bits never reach the word-addressed SRAM
    logic unused_addr_bits;
    assign unused_addr_bits = ^{I_ADDR[1:0], D_ADDR[1:0]};

    mem_arb_rr2 u_arb (
        .CLK   (CLK),
        .RST   (RST),
        .req_i ({D_REQ, I_REQ}),
        .gnt_o (gnt)
    );

    assign I_GNT = gnt[GNT_I];
    assign D_GNT = gnt[GNT_D];

    // Drive the SRAM from whichever port won; idle pins otherwise (also covers reset)
    always_comb begin
        MEM_CSN  = CSN_IDLE;
        MEM_WEN  = WEN_IDLE;
        MEM_BE   = BE_IDLE;
        MEM_ADDR = '0;
        MEM_DOUT = '0;
        owner_d  = OWN_NONE;
        if (gnt[GNT_I]) begin
            MEM_CSN  = 1'b0;
            MEM_BE   = BE_FULL;
            MEM_ADDR = I_ADDR[MAWIDTH+1:2];
            owner_d  = OWN_I;
        end else if (gnt[GNT_D]) begin
            MEM_CSN  = 1'b0;
            MEM_WEN  = ~D_WE;
            MEM_BE   = D_WE ? D_BE : BE_FULL;
            MEM_ADDR = D_ADDR[MAWIDTH+1:2];
            MEM_DOUT = D_WE ? D_WDATA : '0;
            // Writes produce no return data
            owner_d  = D_WE ? OWN_NONE : OWN_D;
        end
    end

    // Remember who gets the SRAM output next cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Read return; reset squashes a return that is in flight
    always_comb begin
        I_RVALID = !RST && (owner_q == OWN_I);
        D_RVALID = !RST && (owner_q == OWN_D);
        I_RDATA  = I_RVALID ? MEM_DI : '0;
        D_RDATA  = D_RVALID ? MEM_DI : '0;
    end

    // Saturating stall counters: a waiting request that was not granted this cycle
    always_comb begin
        i_stall_d = i_stall_q;
        d_stall_d = d_stall_q;
        if (I_REQ && !gnt[GNT_I] && (i_stall_q != CNT_MAX)) begin
            i_stall_d = i_stall_q + 1'b1;
        end
        if (D_REQ && !gnt[GNT_D] && (d_stall_q != CNT_MAX)) begin
            d_stall_d = d_stall_q + 1'b1;
        end
    end

    // Counter state
    always_ff @(posedge CLK) begin
        if (RST) begin
            i_stall_q <= '0;
            d_stall_q <= '0;
        end else begin
            i_stall_q <= i_stall_d;
            d_stall_q <= d_stall_d;
        end
    end

    assign I_STALL_CNT = i_stall_q;
    assign D_STALL_CNT = d_stall_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with a behavioural SP_SRAM and a
// scoreboard that matches every read return against a queued expectation.
module tb_riscv_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        I_REQ;
    logic [11:0] I_ADDR;
    logic        I_GNT, I_RVALID;
    logic [31:0] I_RDATA;
    logic        D_REQ, D_WE;
    logic [11:0] D_ADDR;
    logic [3:0]  D_BE;
    logic [31:0] D_WDATA;
    logic        D_GNT, D_RVALID;
    logic [31:0] D_RDATA;
    logic        MEM_CSN, MEM_WEN;
    logic [3:0]  MEM_BE;
    logic [9:0]  MEM_ADDR;
    logic [31:0] MEM_DOUT;
    logic [31:0] MEM_DI;
    logic [31:0] I_STALL_CNT, D_STALL_CNT;

    // Second instance with narrow counters for the saturation check
    logic [31:0] sat_di = 32'h0;
    logic        sat_unused_ig, sat_unused_iv, sat_unused_dg, sat_unused_dv;
    logic        sat_unused_csn, sat_unused_wen;
    logic [31:0] sat_unused_ird, sat_unused_drd, sat_unused_dout;
    logic [3:0]  sat_unused_be;
    logic [9:0]  sat_unused_addr;
    logic [3:0]  SAT_I_CNT, SAT_D_CNT;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned cyc    = 0;

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t i_exp[$];
    exp_t d_exp[$];

    logic [31:0] mem [0:1023];

    always #5 CLK = ~CLK;

    riscv_mem_arbiter u_dut (
        .CLK         (CLK),
        .RST         (RST),
        .I_REQ       (I_REQ),
        .I_ADDR      (I_ADDR),
        .I_GNT       (I_GNT),
        .I_RVALID    (I_RVALID),
        .I_RDATA     (I_RDATA),
        .D_REQ       (D_REQ),
        .D_WE        (D_WE),
        .D_ADDR      (D_ADDR),
        .D_BE        (D_BE),
        .D_WDATA     (D_WDATA),
        .D_GNT       (D_GNT),
        .D_RVALID    (D_RVALID),
        .D_RDATA     (D_RDATA),
        .MEM_CSN     (MEM_CSN),
        .MEM_WEN     (MEM_WEN),
        .MEM_BE      (MEM_BE),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_DOUT    (MEM_DOUT),
        .MEM_DI      (MEM_DI),
        .I_STALL_CNT (I_STALL_CNT),
        .D_STALL_CNT (D_STALL_CNT)
    );

    riscv_mem_arbiter #(.CNT_WIDTH(4)) u_sat (
        .CLK         (CLK),
        .RST         (RST),
        .I_REQ       (I_REQ),
        .I_ADDR      (I_ADDR),
        .I_GNT       (sat_unused_ig),
        .I_RVALID    (sat_unused_iv),
        .I_RDATA     (sat_unused_ird),
        .D_REQ       (D_REQ),
        .D_WE        (D_WE),
        .D_ADDR      (D_ADDR),
        .D_BE        (D_BE),
        .D_WDATA     (D_WDATA),
        .D_GNT       (sat_unused_dg),
        .D_RVALID    (sat_unused_dv),
        .D_RDATA     (sat_unused_drd),
        .MEM_CSN     (sat_unused_csn),
        .MEM_WEN     (sat_unused_wen),
        .MEM_BE      (sat_unused_be),
        .MEM_ADDR    (sat_unused_addr),
        .MEM_DOUT    (sat_unused_dout),
        .MEM_DI      (sat_di),
        .I_STALL_CNT (SAT_I_CNT),
        .D_STALL_CNT (SAT_D_CNT)
    );

    // Behavioural SP_SRAM: byte-enabled write, registered read
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (!MEM_CSN) begin
            if (!MEM_WEN) begin
                for (int b = 0; b < 4; b++) begin
                    if (MEM_BE[b]) mem[MEM_ADDR][8*b +: 8] <= MEM_DOUT[8*b +: 8];
                end
            end else begin
                MEM_DI <= mem[MEM_ADDR];
            end
        end
    end

    // Background pattern loaded into every word before the overrides
    function automatic logic [31:0] pre(input logic [11:0] byte_addr);
        return {16'hC0DE, 6'b0, byte_addr[11:2]};
    endfunction

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            passed++;
        end
    endfunction

    // Scoreboard monitor: every RVALID must match the oldest queued expectation
    always @(negedge CLK) begin
        exp_t e;
        if (I_RVALID) begin
            if (i_exp.size() == 0) begin
                check("i_unexpected_rvalid", 64'(1), 64'(0));
            end else begin
                e = i_exp.pop_front();
                check("i_rdata", 64'(I_RDATA), 64'(e.data));
                check("i_ret_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else if (i_exp.size() > 0 && i_exp[0].cyc <= cyc) begin
            e = i_exp.pop_front();
            check("i_missing_rvalid", 64'(0), 64'(1));
        end
        if (D_RVALID) begin
            if (d_exp.size() == 0) begin
                check("d_unexpected_rvalid", 64'(1), 64'(0));
            end else begin
                e = d_exp.pop_front();
                check("d_rdata", 64'(D_RDATA), 64'(e.data));
                check("d_ret_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else if (d_exp.size() > 0 && d_exp[0].cyc <= cyc) begin
            e = d_exp.pop_front();
            check("d_missing_rvalid", 64'(0), 64'(1));
        end
    end

    // Requesters must hold REQ until granted
    logic i_wait_prev = 1'b0;
    logic d_wait_prev = 1'b0;
    always @(negedge CLK) begin
        if (!RST && i_wait_prev && !I_REQ) check("i_req_dropped", 64'(0), 64'(1));
        if (!RST && d_wait_prev && !D_REQ) check("d_req_dropped", 64'(0), 64'(1));
        i_wait_prev <= I_REQ && !I_GNT && !RST;
        d_wait_prev <= D_REQ && !D_GNT && !RST;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Check grants at mid-cycle and queue the return each granted read should produce
    task automatic expect_gnt(input logic ei, input logic ed, input logic [31:0] i_data,
                              input logic [31:0] d_data, input logic d_read);
        @(negedge CLK);
        check("I_GNT", 64'(I_GNT), 64'(ei));
        check("D_GNT", 64'(D_GNT), 64'(ed));
        check("MEM_CSN", 64'(MEM_CSN), 64'(!(ei || ed)));
        if (ei) i_exp.push_back('{i_data, cyc + 1});
        if (ed && d_read) d_exp.push_back('{d_data, cyc + 1});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = {16'hC0DE, 16'(k)};
        mem[4]     = 32'h00500093;
        mem[10'h200] = 32'hFFFFFFFF;

        // Reset with both ports requesting
        RST = 1'b1; I_REQ = 1'b1; I_ADDR = 12'h020;
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 12'h024; D_BE = 4'h0; D_WDATA = 32'h0;
        for (int k = 0; k < 3; k++) begin
            expect_gnt(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            check("rst MEM_WEN", 64'(MEM_WEN), 64'(1));
            check("rst MEM_BE", 64'(MEM_BE), 64'(0));
            check("rst D_RDATA", 64'(D_RDATA), 64'(0));
            check("rst I_RVALID", 64'(I_RVALID), 64'(0));
            if (k > 0) begin
                check("rst I_STALL_CNT", 64'(I_STALL_CNT), 64'(0));
                check("rst D_STALL_CNT", 64'(D_STALL_CNT), 64'(0));
            end
            tick();
        end
        RST = 1'b0;
        expect_gnt(1'b1, 1'b0, pre(12'h020), 32'h0, 1'b0);
        tick();
        I_REQ = 1'b0;
        expect_gnt(1'b0, 1'b1, 32'h0, pre(12'h024), 1'b1);
        check("post-rst D_STALL_CNT", 64'(D_STALL_CNT), 64'(1));
        check("post-rst I_STALL_CNT", 64'(I_STALL_CNT), 64'(0));
        tick();
        D_REQ = 1'b0;
        tick();

        // Lone fetch
        I_REQ = 1'b1; I_ADDR = 12'h010;
        expect_gnt(1'b1, 1'b0, 32'h00500093, 32'h0, 1'b0);
        check("fetch MEM_ADDR", 64'(MEM_ADDR), 64'(10'h004));
        check("fetch MEM_WEN", 64'(MEM_WEN), 64'(1));
        check("fetch MEM_BE", 64'(MEM_BE), 64'(4'hF));
        tick();
        I_REQ = 1'b0;
        @(negedge CLK);
        check("fetch D_RVALID", 64'(D_RVALID), 64'(0));
        check("fetch D_RDATA", 64'(D_RDATA), 64'(0));
        tick();

        // Contention: I,D,I,D then the waiting I
        RST = 1'b1; tick(); RST = 1'b0;
        I_REQ = 1'b1; I_ADDR = 12'h040; D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 12'h044;
        expect_gnt(1'b1, 1'b0, pre(12'h040), 32'h0, 1'b0);
        check("c1 MEM_ADDR", 64'(MEM_ADDR), 64'(10'h010));
        tick(); I_ADDR = 12'h048;
        expect_gnt(1'b0, 1'b1, 32'h0, pre(12'h044), 1'b1);
        check("c2 MEM_ADDR", 64'(MEM_ADDR), 64'(10'h011));
        tick(); D_ADDR = 12'h04C;
        expect_gnt(1'b1, 1'b0, pre(12'h048), 32'h0, 1'b0);
        check("c3 MEM_ADDR", 64'(MEM_ADDR), 64'(10'h012));
        tick(); I_ADDR = 12'h050;
        expect_gnt(1'b0, 1'b1, 32'h0, pre(12'h04C), 1'b1);
        check("c4 MEM_ADDR", 64'(MEM_ADDR), 64'(10'h013));
        tick(); D_REQ = 1'b0;
        expect_gnt(1'b1, 1'b0, pre(12'h050), 32'h0, 1'b0);
        check("cont I_STALL_CNT", 64'(I_STALL_CNT), 64'(2));
        check("cont D_STALL_CNT", 64'(D_STALL_CNT), 64'(2));
        tick(); I_REQ = 1'b0;
        tick();

        // Byte write to word 0x200 then read back
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 12'h800; D_BE = 4'b0011; D_WDATA = 32'h12345678;
        expect_gnt(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        check("wr MEM_WEN", 64'(MEM_WEN), 64'(0));
        check("wr MEM_BE", 64'(MEM_BE), 64'(4'b0011));
        check("wr MEM_DOUT", 64'(MEM_DOUT), 64'(32'h12345678));
        check("wr MEM_ADDR", 64'(MEM_ADDR), 64'(10'h200));
        tick();
        D_WE = 1'b0; D_BE = 4'h0; D_WDATA = 32'h0;
        expect_gnt(1'b0, 1'b1, 32'h0, 32'hFFFF5678, 1'b1);
        check("wr no D_RVALID", 64'(D_RVALID), 64'(0));
        check("rd MEM_BE", 64'(MEM_BE), 64'(4'hF));
        check("rd MEM_DOUT", 64'(MEM_DOUT), 64'(0));
        tick();
        D_REQ = 1'b0;
        tick();

        // Read granted, then reset the next cycle with a write pending
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 12'h100;
        expect_gnt(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tick();
        RST = 1'b1; D_WE = 1'b1; D_ADDR = 12'h800; D_BE = 4'hF; D_WDATA = 32'h0;
        expect_gnt(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("rstmid D_RVALID n+1", 64'(D_RVALID), 64'(0));
        check("rstmid MEM_WEN", 64'(MEM_WEN), 64'(1));
        tick();
        RST = 1'b0; D_REQ = 1'b0; D_WE = 1'b0; D_BE = 4'h0;
        @(negedge CLK);
        check("rstmid D_RVALID n+2", 64'(D_RVALID), 64'(0));
        tick();

        // Continuous contention: 4-bit counters must saturate at 15
        RST = 1'b1; tick(); RST = 1'b0;
        I_REQ = 1'b1; I_ADDR = 12'h0C0; D_REQ = 1'b1; D_ADDR = 12'h0C4;
        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 0) expect_gnt(1'b1, 1'b0, pre(12'h0C0), 32'h0, 1'b0);
            else            expect_gnt(1'b0, 1'b1, 32'h0, pre(12'h0C4), 1'b1);
            if (k == 10) begin
                check("sat I at 10", 64'(SAT_I_CNT), 64'(5));
                check("sat D at 10", 64'(SAT_D_CNT), 64'(5));
            end
            if (k == 31) begin
                check("sat I at 31", 64'(SAT_I_CNT), 64'(15));
                check("sat D at 31", 64'(SAT_D_CNT), 64'(15));
            end
            tick();
        end
        D_REQ = 1'b0;
        expect_gnt(1'b1, 1'b0, pre(12'h0C0), 32'h0, 1'b0);
        tick();
        I_REQ = 1'b0;
        @(negedge CLK);
        check("sat I final", 64'(SAT_I_CNT), 64'(15));
        check("sat D final", 64'(SAT_D_CNT), 64'(15));
        check("wide I final", 64'(I_STALL_CNT), 64'(20));
        check("wide D final", 64'(D_STALL_CNT), 64'(20));
        tick();

        // Word 0x200 must be untouched by the write attempted during reset
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 12'h800;
        expect_gnt(1'b0, 1'b1, 32'h0, 32'hFFFF5678, 1'b1);
        tick();
        D_REQ = 1'b0;
        tick();
        tick();

        check("i_exp drained", 64'(i_exp.size()), 64'(0));
        check("d_exp drained", 64'(d_exp.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
